// File: rtl/prediction_pkg.sv
// Shared constants, types and helpers for the branch direction predictor.
// Register map offsets, control bits, FSM states, counter arithmetic.
package prediction_pkg;

   localparam logic [1:0] ADR_CTRL = 2'd0;
   localparam logic [1:0] ADR_PRED = 2'd1;
   localparam logic [1:0] ADR_MISP = 2'd2;
   localparam logic [1:0] ADR_GHR  = 2'd3;

   localparam int CTRL_CLR_BIT  = 0;
   localparam int CTRL_BUSY_BIT = 1;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   // Saturating step of a direction counter (widths up to 4 bits).
   function automatic logic [3:0] sat_update(
      input logic [3:0] cnt_i,
      input logic       taken_i,
      input logic [3:0] max_i
   );
      logic [3:0] res;
      res = cnt_i;
      if (taken_i) begin
         if (cnt_i != max_i) res = cnt_i + 4'd1;
      end else begin
         if (cnt_i != 4'd0) res = cnt_i - 4'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/prediction_table.sv
// Flop array of saturating direction counters.
// Registered read port, saturating update port, clear port (wins).
module prediction_table #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             rd_en_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [CNT_W-1:0] rd_cnt_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i,
   input  logic             clr_en_i,
   input  logic [IDX_W-1:0] clr_idx_i
);
   import prediction_pkg::*;

   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q [DEPTH];
   logic [CNT_W-1:0] rd_cnt_q;
   logic [CNT_W-1:0] upd_val;

   assign upd_val = CNT_W'(sat_update(4'(cnt_q[upd_idx_i]),
                                      upd_taken_i, 4'(CNT_MAX)));

   // Counter storage: clear write overrides a resolved-branch update.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_WNT;
      end else if (clr_en_i) begin
         cnt_q[clr_idx_i] <= CNT_WNT;
      end else if (upd_en_i) begin
         cnt_q[upd_idx_i] <= upd_val;
      end
   end

   // Read port samples pre-update contents, so a same-cycle update is not seen.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_cnt_q <= '0;
      else if (rd_en_i) rd_cnt_q <= cnt_q[rd_idx_i];
   end

   assign rd_cnt_o = rd_cnt_q;

endmodule

// File: rtl/prediction_gshare.sv
// Bimodal/gshare branch direction predictor with table-clear FSM
// and a Wishbone-readable statistics/control block.
module prediction_gshare #(
   parameter int PC_W   = 16,
   parameter int IDX_W  = 4,
   parameter int HIST_W = 4,
   parameter int CNT_W  = 2,
   parameter int MODE   = 1,
   parameter int STAT_W = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              pred_valid_i,
   output logic              pred_ready_o,
   input  logic [PC_W-1:0]   pred_pc_i,
   output logic              resp_valid_o,
   output logic              resp_taken_o,
   output logic [IDX_W-1:0]  resp_idx_o,
   input  logic              upd_valid_i,
   input  logic [IDX_W-1:0]  upd_idx_i,
   input  logic              upd_taken_i,
   input  logic              upd_pred_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o
);
   import prediction_pkg::*;

   state_e state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [HIST_W-1:0] ghr_q, ghr_d;
   logic [STAT_W-1:0] pred_cnt_q, pred_cnt_d;
   logic [STAT_W-1:0] misp_cnt_q, misp_cnt_d;
   logic              resp_valid_q;
   logic [IDX_W-1:0]  resp_idx_q;
   logic              ack_q;
   logic [31:0]       dat_q, dat_d;

   logic              busy, accept, upd_en, clr_en;
   logic              wb_req, clr_req;
   logic [1:0]        wb_sel;
   logic [31:0]       rd_data;
   logic [IDX_W-1:0]  base_idx, pred_idx;
   logic [CNT_W-1:0]  rd_cnt;
   logic              unused_ok;

   assign busy         = (state_q == ST_INIT);
   assign pred_ready_o = !busy;
   assign accept       = pred_valid_i & pred_ready_o;
   assign upd_en       = upd_valid_i & !busy;

   assign wb_req  = wbs_cyc_i & wbs_stb_i & !ack_q;
   assign wb_sel  = wbs_adr_i[3:2];
   assign clr_req = wb_req & wbs_we_i & (wb_sel == ADR_CTRL)
                  & wbs_dat_i[CTRL_CLR_BIT];

   assign base_idx = pred_pc_i[IDX_W+1:2];
   assign pred_idx = (MODE == 1) ? (base_idx ^ IDX_W'(ghr_q)) : base_idx;

   assign unused_ok = ^{wbs_adr_i, wbs_dat_i, pred_pc_i, rd_cnt};

   // Clear sequencer: walk every entry once, then serve predictions.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      clr_en  = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            clr_en = 1'b1;
            ptr_d  = ptr_q + IDX_W'(1);
            if (ptr_q == '1) state_d = ST_RUN;
         end
         ST_RUN: begin
         end
      endcase
      if (clr_req) begin
         state_d = ST_INIT;
         ptr_d   = '0;
      end
   end

   // History shift and saturating statistics; a clear wipes all of them.
   always_comb begin
      ghr_d      = ghr_q;
      pred_cnt_d = pred_cnt_q;
      misp_cnt_d = misp_cnt_q;
      if (clr_req) begin
         ghr_d      = '0;
         pred_cnt_d = '0;
         misp_cnt_d = '0;
      end else begin
         if (upd_en) ghr_d = HIST_W'({ghr_q, upd_taken_i});
         if (accept && pred_cnt_q != '1)
            pred_cnt_d = pred_cnt_q + STAT_W'(1);
         if (upd_en && (upd_taken_i != upd_pred_i) && misp_cnt_q != '1)
            misp_cnt_d = misp_cnt_q + STAT_W'(1);
      end
   end

   // Register read mux; read data is latched only on an accepted read.
   always_comb begin
      rd_data = '0;
      unique case (1'b1)
         (wb_sel == ADR_CTRL): rd_data[CTRL_BUSY_BIT] = busy;
         (wb_sel == ADR_PRED): rd_data = 32'(pred_cnt_q);
         (wb_sel == ADR_MISP): rd_data = 32'(misp_cnt_q);
         (wb_sel == ADR_GHR):  rd_data = 32'(ghr_q);
      endcase
      dat_d = dat_q;
      if (wb_req && !wbs_we_i) dat_d = rd_data;
   end

   // State, history, statistics, response and bus registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q      <= ST_INIT;
         ptr_q        <= '0;
         ghr_q        <= '0;
         pred_cnt_q   <= '0;
         misp_cnt_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_idx_q   <= '0;
         ack_q        <= 1'b0;
         dat_q        <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         ghr_q        <= ghr_d;
         pred_cnt_q   <= pred_cnt_d;
         misp_cnt_q   <= misp_cnt_d;
         resp_valid_q <= accept;
         if (accept) resp_idx_q <= pred_idx;
         ack_q        <= wb_req;
         dat_q        <= dat_d;
      end
   end

   prediction_table #(
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) u_table (
      .clk_i       (wb_clk_i),
      .rst_ni      (wb_rst_n),
      .rd_en_i     (accept),
      .rd_idx_i    (pred_idx),
      .rd_cnt_o    (rd_cnt),
      .upd_en_i    (upd_en),
      .upd_idx_i   (upd_idx_i),
      .upd_taken_i (upd_taken_i),
      .clr_en_i    (clr_en),
      .clr_idx_i   (ptr_q)
   );

   assign resp_valid_o = resp_valid_q;
   assign resp_taken_o = rd_cnt[CNT_W-1];
   assign resp_idx_o   = resp_idx_q;
   assign wbs_ack_o    = ack_q;
   assign wbs_dat_o    = dat_q;

endmodule
